// File: rtl/adaptive_threshold_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// adaptive_threshold_sequencer_pkg
//
// Shared definitions for the adaptive-thresholding pipeline:
//   - default image dimensions (log2), shared with the mean and binarize stages
//   - 3-bit state encoding of the top-level sequencer
// ----------------------------------------------------------------------------
package adaptive_threshold_sequencer_pkg;

    // Default image geometry (log2 of width / height).
    localparam int DEFAULT_WIDTH_BITS  = 8;
    localparam int DEFAULT_HEIGHT_BITS = 8;

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
    localparam logic [2:0] ST_CALC_RUN_ENC  = 3'd1;
    localparam logic [2:0] ST_BIN_RUN_ENC   = 3'd2;
    localparam logic [2:0] ST_BIN_DRAIN_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC      = 3'd4;
    localparam logic [2:0] ST_ERROR_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_CALC_RUN  = ST_CALC_RUN_ENC,
        ST_BIN_RUN   = ST_BIN_RUN_ENC,
        ST_BIN_DRAIN = ST_BIN_DRAIN_ENC,
        ST_DONE      = ST_DONE_ENC,
        ST_ERROR     = ST_ERROR_ENC
    } seq_state_t;

endpackage

// File: rtl/adaptive_threshold_sequencer_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//
// Up-counter that sticks at all-ones instead of wrapping.
//   clock   : rising-edge clock
//   reset   : synchronous, active-high; clears the count
//   clear   : synchronous clear (below reset in priority)
//   enable  : count up by one when not saturated
//   count   : current value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/adaptive_threshold_sequencer.sv
// ----------------------------------------------------------------------------
// adaptive_threshold_sequencer
//
// Runs the local-mean stage, then the binarize stage, then reports done.
// Each stage is held in reset while it is not active; the single image-memory
// read address is muxed from whichever stage is running. A saturating total
// cycle count and a per-stage watchdog are provided.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   iStart                        start request (accepted in IDLE/DONE/ERROR)
//   oBusy, oDone, oError          run status (registered)
//   oCalcReset, iCalcFinished     mean-stage reset / finished handshake
//   oBinReset,  iBinFinished      binarize-stage reset / finished handshake
//   iCalcImageCol/Row             address requested by the mean stage
//   iBinImageCol/Row              address requested by the binarize stage
//   oImageCol/Row                 muxed image-memory address (combinational)
//   oCycles                       cycles spent in the last or current run
// ----------------------------------------------------------------------------
module adaptive_threshold_sequencer
    import adaptive_threshold_sequencer_pkg::*;
#(
    parameter int WIDTH_BITS       = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS      = DEFAULT_HEIGHT_BITS,
    parameter int STAGE_CNT_BITS   = WIDTH_BITS + HEIGHT_BITS + 2,
    parameter int MAX_STAGE_CYCLES = 2 * (2 ** (WIDTH_BITS + HEIGHT_BITS)),
    parameter int CYCLE_BITS       = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oError,
    output logic                   oCalcReset,
    input  logic                   iCalcFinished,
    output logic                   oBinReset,
    input  logic                   iBinFinished,
    input  logic [WIDTH_BITS-1:0]  iCalcImageCol,
    input  logic [HEIGHT_BITS-1:0] iCalcImageRow,
    input  logic [WIDTH_BITS-1:0]  iBinImageCol,
    input  logic [HEIGHT_BITS-1:0] iBinImageRow,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    output logic [CYCLE_BITS-1:0]  oCycles
);

    localparam logic [STAGE_CNT_BITS-1:0] WD_LIMIT =
        STAGE_CNT_BITS'(MAX_STAGE_CYCLES - 1);

    seq_state_t                state;
    logic [STAGE_CNT_BITS-1:0] stage_cnt;

    logic start_accept;
    logic wd_expired;
    logic stage_clear;
    logic stage_enable;
    logic cycle_enable;

    assign start_accept = iStart &&
        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign wd_expired   = (stage_cnt == WD_LIMIT);

    // The watchdog restarts for each stage: on run start and on the
    // mean -> binarize hand-over.
    assign stage_clear  = start_accept || ((state == ST_CALC_RUN) && iCalcFinished);
    assign stage_enable = (state == ST_CALC_RUN) || (state == ST_BIN_RUN);
    assign cycle_enable = stage_enable || (state == ST_BIN_DRAIN);

    sat_counter #(
        .WIDTH (STAGE_CNT_BITS)
    ) u_stage_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (stage_clear),
        .enable (stage_enable),
        .count  (stage_cnt)
    );

    sat_counter #(
        .WIDTH (CYCLE_BITS)
    ) u_cycle_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_accept),
        .enable (cycle_enable),
        .count  (oCycles)
    );

    // Status and stage resets are registered alongside the state, so each is
    // written with the value belonging to the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oError     <= 1'b0;
            oCalcReset <= 1'b1;
            oBinReset  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (iStart) begin
                        state      <= ST_CALC_RUN;
                        oBusy      <= 1'b1;
                        oDone      <= 1'b0;
                        oError     <= 1'b0;
                        oCalcReset <= 1'b0;
                    end
                end
                ST_CALC_RUN: begin
                    // A finished flag on the expiry cycle still counts as success.
                    if (iCalcFinished) begin
                        state      <= ST_BIN_RUN;
                        oCalcReset <= 1'b1;
                        oBinReset  <= 1'b0;
                    end else if (wd_expired) begin
                        state      <= ST_ERROR;
                        oBusy      <= 1'b0;
                        oError     <= 1'b1;
                        oCalcReset <= 1'b1;
                    end
                end
                ST_BIN_RUN: begin
                    if (iBinFinished) begin
                        state <= ST_BIN_DRAIN;
                    end else if (wd_expired) begin
                        state     <= ST_ERROR;
                        oBusy     <= 1'b0;
                        oError    <= 1'b1;
                        oBinReset <= 1'b1;
                    end
                end
                ST_BIN_DRAIN: begin
                    // One extra cycle out of reset lets the binarizer land its
                    // last result write.
                    state     <= ST_DONE;
                    oBusy     <= 1'b0;
                    oDone     <= 1'b1;
                    oBinReset <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    oBusy      <= 1'b0;
                    oDone      <= 1'b0;
                    oError     <= 1'b0;
                    oCalcReset <= 1'b1;
                    oBinReset  <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: outputs get a default before the case so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        oImageCol = '0;
        oImageRow = '0;
        case (state)
            ST_CALC_RUN: begin
                oImageCol = iCalcImageCol;
                oImageRow = iCalcImageRow;
            end
            ST_BIN_RUN, ST_BIN_DRAIN: begin
                oImageCol = iBinImageCol;
                oImageRow = iBinImageRow;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adaptive_threshold_sequencer
//
// Three sequencer instances on a 4x4 image:
//   0: default watchdog (32), 24-bit cycle counter  - main run, mux, restart, reset
//   1: watchdog at 8 cycles                          - error path, finished-vs-expiry
//   2: 4-bit cycle counter                           - cycle count saturation
// Each instance has behavioural mean/binarize stage models that raise their
// finished flag a programmable number of cycles after their reset drops.
// ----------------------------------------------------------------------------
module tb_adaptive_threshold_sequencer;

    localparam logic [1:0] CALC_COL = 2'd1;
    localparam logic [1:0] CALC_ROW = 2'd2;
    localparam logic [1:0] BIN_COL  = 2'd3;
    localparam logic [1:0] BIN_ROW  = 2'd0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       start     [3];
    logic       busy      [3];
    logic       done      [3];
    logic       err       [3];
    logic       crst      [3];
    logic       brst      [3];
    logic       calc_fin  [3];
    logic       bin_fin   [3];
    logic [1:0] col       [3];
    logic [1:0] row       [3];
    logic [23:0] cycles_a;
    logic [23:0] cycles_b;
    logic [3:0]  cycles_c;

    int calc_lat   [3];
    int bin_lat    [3];
    bit calc_force [3];
    bit bin_force  [3];
    int calc_cnt   [3];
    int bin_cnt    [3];

    int checks = 0;
    int errors = 0;

    adaptive_threshold_sequencer #(
        .WIDTH_BITS (2), .HEIGHT_BITS (2)
    ) dut_a (
        .clock (clock), .reset (reset), .iStart (start[0]),
        .oBusy (busy[0]), .oDone (done[0]), .oError (err[0]),
        .oCalcReset (crst[0]), .iCalcFinished (calc_fin[0]),
        .oBinReset (brst[0]), .iBinFinished (bin_fin[0]),
        .iCalcImageCol (CALC_COL), .iCalcImageRow (CALC_ROW),
        .iBinImageCol (BIN_COL), .iBinImageRow (BIN_ROW),
        .oImageCol (col[0]), .oImageRow (row[0]), .oCycles (cycles_a)
    );

    adaptive_threshold_sequencer #(
        .WIDTH_BITS (2), .HEIGHT_BITS (2), .MAX_STAGE_CYCLES (8)
    ) dut_b (
        .clock (clock), .reset (reset), .iStart (start[1]),
        .oBusy (busy[1]), .oDone (done[1]), .oError (err[1]),
        .oCalcReset (crst[1]), .iCalcFinished (calc_fin[1]),
        .oBinReset (brst[1]), .iBinFinished (bin_fin[1]),
        .iCalcImageCol (CALC_COL), .iCalcImageRow (CALC_ROW),
        .iBinImageCol (BIN_COL), .iBinImageRow (BIN_ROW),
        .oImageCol (col[1]), .oImageRow (row[1]), .oCycles (cycles_b)
    );

    adaptive_threshold_sequencer #(
        .WIDTH_BITS (2), .HEIGHT_BITS (2), .CYCLE_BITS (4)
    ) dut_c (
        .clock (clock), .reset (reset), .iStart (start[2]),
        .oBusy (busy[2]), .oDone (done[2]), .oError (err[2]),
        .oCalcReset (crst[2]), .iCalcFinished (calc_fin[2]),
        .oBinReset (brst[2]), .iBinFinished (bin_fin[2]),
        .iCalcImageCol (CALC_COL), .iCalcImageRow (CALC_ROW),
        .iBinImageCol (BIN_COL), .iBinImageRow (BIN_ROW),
        .oImageCol (col[2]), .oImageRow (row[2]), .oCycles (cycles_c)
    );

    // Stage models: count cycles out of reset; finished is high on the
    // cycle where the count reaches latency-1 (latency 0 = never finishes).
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            calc_cnt[i] <= crst[i] ? 0 : calc_cnt[i] + 1;
            bin_cnt[i]  <= brst[i] ? 0 : bin_cnt[i] + 1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_model
        assign calc_fin[g] = calc_force[g] ||
            (!crst[g] && (calc_lat[g] != 0) && (calc_cnt[g] == calc_lat[g] - 1));
        assign bin_fin[g]  = bin_force[g] ||
            (!brst[g] && (bin_lat[g] != 0) && (bin_cnt[g] == bin_lat[g] - 1));
    end

    typedef struct {
        int cyc;
        bit busy;
        bit done;
        bit err;
        bit crst;
        bit brst;
        int cycles;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cycles_of(input int k);
        case (k)
            0:       return {8'd0, cycles_a};
            1:       return {8'd0, cycles_b};
            default: return {28'd0, cycles_c};
        endcase
    endfunction

    // Compares all outputs of instance k; the expected address follows from
    // which stage is expected to be out of reset.
    task automatic check_snap(input string tag, input int k, input bit e_busy,
                              input bit e_done, input bit e_err, input bit e_crst,
                              input bit e_brst, input int e_cycles);
        logic [1:0] e_col;
        logic [1:0] e_row;
        e_col = !e_crst ? CALC_COL : (!e_brst ? BIN_COL : 2'd0);
        e_row = !e_crst ? CALC_ROW : (!e_brst ? BIN_ROW : 2'd0);
        check($sformatf("%s busy", tag),   busy[k], e_busy);
        check($sformatf("%s done", tag),   done[k], e_done);
        check($sformatf("%s error", tag),  err[k],  e_err);
        check($sformatf("%s calc_rst", tag), crst[k], e_crst);
        check($sformatf("%s bin_rst", tag),  brst[k], e_brst);
        check($sformatf("%s col", tag),    col[k],  e_col);
        check($sformatf("%s row", tag),    row[k],  e_row);
        check($sformatf("%s cycles", tag), cycles_of(k), e_cycles);
    endtask

    // Cycle t1 follows the edge that samples the start pulse.
    task automatic start_run(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t;

        //            cyc busy done err crst brst cycles
        vecs[0] = '{ 1, 1, 0, 0, 0, 1,  0};
        vecs[1] = '{ 2, 1, 0, 0, 0, 1,  1};
        vecs[2] = '{16, 1, 0, 0, 0, 1, 15};
        vecs[3] = '{17, 1, 0, 0, 1, 0, 16};
        vecs[4] = '{32, 1, 0, 0, 1, 0, 31};
        vecs[5] = '{33, 1, 0, 0, 1, 0, 32};
        vecs[6] = '{34, 0, 1, 0, 1, 1, 33};
        vecs[7] = '{36, 0, 1, 0, 1, 1, 33};

        calc_lat = '{16, 0, 16};
        bin_lat  = '{16, 8, 16};
        for (int i = 0; i < 3; i++) begin
            start[i]      = 1'b0;
            calc_force[i] = 1'b0;
            bin_force[i]  = 1'b0;
        end

        reset = 1'b1;
        advance(3);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) check_snap($sformatf("reset[%0d]", k), k, 0, 0, 0, 1, 1, 0);

        // ---- Main run on instance 0, table driven ----
        start_run(0);
        t = 1;
        for (int v = 0; v < 8; v++) begin
            while (t < vecs[v].cyc) begin
                tick();
                t++;
            end
            check_snap($sformatf("run t%0d", t), 0, vecs[v].busy, vecs[v].done,
                       vecs[v].err, vecs[v].crst, vecs[v].brst, vecs[v].cycles);
        end

        // Start held across DONE restarts at once and is ignored while running.
        start[0] = 1'b1;
        tick();
        check_snap("restart", 0, 1, 0, 0, 0, 1, 0);
        tick();
        check_snap("start held in calc", 0, 1, 0, 0, 0, 1, 1);
        start[0] = 1'b0;

        // Reach BIN_RUN, then reset for one cycle.
        for (int i = 0; i < 40 && brst[0] !== 1'b0; i++) tick();
        check("wait bin_run", brst[0], 1'b0);
        advance(2);
        reset = 1'b1;
        tick();
        check_snap("mid-run reset", 0, 0, 0, 0, 1, 1, 0);
        reset = 1'b0;

        // Stale finished levels in IDLE do nothing.
        calc_force[0] = 1'b1;
        bin_force[0]  = 1'b1;
        advance(3);
        check_snap("stale finished", 0, 0, 0, 0, 1, 1, 0);
        calc_force[0] = 1'b0;
        bin_force[0]  = 1'b0;

        // ---- Watchdog on instance 1 (limit 8, calc never finishes) ----
        start_run(1);
        advance(7);
        check_snap("wd t8", 1, 1, 0, 0, 0, 1, 7);
        tick();
        check_snap("wd t9 error", 1, 0, 0, 1, 1, 1, 8);
        tick();
        check_snap("wd t10 frozen", 1, 0, 0, 1, 1, 1, 8);

        // Restart from ERROR; calc finishes exactly at watchdog expiry.
        calc_lat[1] = 8;
        start_run(1);
        check_snap("err restart", 1, 1, 0, 0, 0, 1, 0);
        advance(8);
        check_snap("finish beats wd", 1, 1, 0, 0, 1, 0, 8);
        tick();
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check_snap("start in bin", 1, 1, 0, 0, 1, 0, 10);
        tick();
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        advance(5);
        check_snap("wd path done", 1, 0, 1, 0, 1, 1, 17);

        // ---- Cycle counter saturation on instance 2 (4 bits) ----
        start_run(2);
        advance(15);
        check_snap("sat t16", 2, 1, 0, 0, 0, 1, 15);
        tick();
        check_snap("sat t17", 2, 1, 0, 0, 1, 0, 15);
        advance(17);
        check_snap("sat t34 done", 2, 0, 1, 0, 1, 1, 15);
        advance(2);
        check_snap("sat t36 done", 2, 0, 1, 0, 1, 1, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adaptive_threshold_sequencer.md
Name: adaptive_threshold_sequencer

Overview:
Top-level sequencer for the adaptive-thresholding pipeline. On a start pulse it runs the local-mean stage, which fills the threshold memory, then runs the binarization stage, which fills the result memory, then reports done. It holds each stage in reset when that stage is not active, and owns the single image-memory read address port shared by both stages. It also provides a total cycle count and a per-stage watchdog.

Parameters:
WIDTH_BITS, 8, log2 of image width
HEIGHT_BITS, 8, log2 of image height
STAGE_CNT_BITS, WIDTH_BITS+HEIGHT_BITS+2, width of the per-stage watchdog counter
MAX_STAGE_CYCLES, 2*(2**(WIDTH_BITS+HEIGHT_BITS)), stage runtime above which the watchdog fires
CYCLE_BITS, 24, width of the total cycle counter

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
iStart  in  1  start request; sampled only in IDLE, DONE or ERROR
oBusy  out  1  high from the first cycle after an accepted start until DONE or ERROR
oDone  out  1  high while in DONE
oError  out  1  high while in ERROR (watchdog expired)
oCalcReset  out  1  reset to the mean stage; low only in CALC_RUN
iCalcFinished  in  1  finished flag from the mean stage
oBinReset  out  1  reset to the binarize stage; low only in BIN_RUN and BIN_DRAIN
iBinFinished  in  1  finished flag from the binarize stage
iCalcImageCol  in  WIDTH_BITS  image column requested by the mean stage
iCalcImageRow  in  HEIGHT_BITS  image row requested by the mean stage
iBinImageCol  in  WIDTH_BITS  image column requested by the binarize stage
iBinImageRow  in  HEIGHT_BITS  image row requested by the binarize stage
oImageCol  out  WIDTH_BITS  muxed column to the image memory
oImageRow  out  HEIGHT_BITS  muxed row to the image memory
oCycles  out  CYCLE_BITS  cycles spent in the last or current run

Behaviour:
- States: IDLE, CALC_RUN, BIN_RUN, BIN_DRAIN, DONE, ERROR. All outputs are registered except the address mux.
- Reset (synchronous, takes priority over everything):
  - state goes to IDLE
  - oBusy, oDone, oError are 0
  - oCalcReset and oBinReset are 1
  - oCycles and the stage counter are 0
- Reset mid-run forces both stages back into reset on the next edge and abandons the run.
- Transitions:
  - IDLE/DONE/ERROR, iStart=1 -> CALC_RUN. On the same edge: oCycles cleared, stage counter cleared, oDone and oError cleared.
  - CALC_RUN, iCalcFinished=1 -> BIN_RUN; stage counter cleared.
  - BIN_RUN, iBinFinished=1 -> BIN_DRAIN. The binarizer performs its final result write one cycle after finished rises; BIN_DRAIN keeps oBinReset low for exactly that cycle.
  - BIN_DRAIN -> DONE unconditionally, after 1 cycle.
  - CALC_RUN or BIN_RUN with stage counter == MAX_STAGE_CYCLES-1 and no finished flag -> ERROR.
- Simultaneous finished flag and watchdog expiry: finished wins.
- iStart is ignored in CALC_RUN, BIN_RUN and BIN_DRAIN.
- iStart held high across DONE restarts the run immediately; no idle cycle is required.
- Finished inputs are ignored in every state other than their own RUN state. A stale high level while the stage is in reset has no effect.
- Stage resets: oCalcReset = 0 in CALC_RUN, else 1. oBinReset = 0 in BIN_RUN and BIN_DRAIN, else 1. In ERROR both are 1, which quiesces the memory writers.
- Address mux (combinational from the state register):
  - CALC_RUN: calc-stage inputs
  - BIN_RUN and BIN_DRAIN: binarize-stage inputs
  - all other states: 0
- oCycles:
  - increments by 1 on every edge while in CALC_RUN, BIN_RUN or BIN_DRAIN
  - saturates at all-ones with no wrap
  - frozen in DONE/ERROR until the next accepted start
- Stage counter: increments in RUN states and saturates at all-ones.
- Latency: the start edge is followed by CALC_RUN on the next cycle. oDone rises 1 cycle after BIN_DRAIN, i.e. 2 cycles after iBinFinished is sampled high.

Decomposition:
- Shared package holds:
  - state encoding (3-bit localparams for the six states)
  - the default image dimension parameters, shared with the mean and binarize stages
- One natural sub-module: sat_counter, a parameterised saturating counter with synchronous clear and enable.
  - Instantiated twice: once for oCycles, once for the watchdog.
- FSM and mux stay in the top module.

Test Plan:
- WIDTH_BITS=HEIGHT_BITS=2; stage models assert finished 16 cycles after their reset drops; iStart pulse at t0:
  - CALC_RUN from t1 to t16, BIN_RUN from t17 to t32, BIN_DRAIN at t33, oDone=1 from t34
  - oCycles=33
- Address mux: calc inputs driven as 0x1/0x2 and bin inputs as 0x3/0x0.
  - oImageCol/Row = 1/2 only during CALC_RUN
  - 3/0 only during BIN_RUN and BIN_DRAIN
  - 0 otherwise
- MAX_STAGE_CYCLES=8 with calc finished never asserted -> ERROR at cycle 9 after start; oError=1, both stage resets 1, oBusy=0.
  - A subsequent iStart clears oError and re-enters CALC_RUN.
- iCalcFinished high on the same edge the watchdog reaches 7 -> BIN_RUN, not ERROR.
  - iStart pulses during BIN_RUN are ignored; oCycles is unaffected.
- Synchronous reset asserted mid BIN_RUN for 1 cycle -> IDLE; oBinReset=1, oCycles=0, oBusy=0 on the next edge.
  - A stale iBinFinished=1 held in IDLE causes no transition.
- CYCLE_BITS=4 with a 16-cycle stage model -> oCycles saturates at 15 and stays 15 in DONE.
